// File: rtl/elevator_call_latch_pkg.sv
// elevator_pkg: shared constants, debounce state encoding and counter sizing for the call latch
package elevator_pkg;
    localparam int DEF_NFLOORS = 3;
    localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, HELD = 2'd2, REL = 2'd3;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/elevator_call_latch_if.sv
// elevator_call_latch_if: button, call-reset, call and pending-count signals between panel and controller
interface elevator_call_latch_if
    import elevator_pkg::*;
#(
    parameter int NFLOORS = DEF_NFLOORS
) ();
    logic [NFLOORS:1] P;
    logic [NFLOORS:1] R;
    logic [NFLOORS:1] B;
    logic [NFLOORS:1] CXL;
    logic [$clog2(NFLOORS+1)-1:0] PEND;
    modport master (output P, output R, input B, input PEND, input CXL);
    modport slave (input P, input R, output B, output PEND, output CXL);
endinterface

// File: rtl/elevator_call_latch_button_debounce.sv
// elevator_button_debounce: per-floor synchroniser and debounce FSM; CALL_CANCEL_EN adds long-hold cancel
module elevator_button_debounce
    import elevator_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int CANCEL_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic p,
    output logic set,
    output logic cancel
);
    // One width serves both the debounce counter and the hold counter.
    localparam int CW = cnt_w(DEB_CYCLES > CANCEL_CYCLES ? DEB_CYCLES : CANCEL_CYCLES);
    localparam logic [CW-1:0] DEB_M = CW'(DEB_CYCLES);
    logic [1:0] sync_q, sync_d, state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic s, pressing, done;
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        sync_d   = {sync_q[0], p};
        s        = sync_q[1];
        cnt_inc  = cnt_q + CW'(1);
        done     = cnt_inc == DEB_M;
        pressing = state_q == IDLE || state_q == ARM;
        state_d  = pressing ? (s ? IDLE : done ? HELD : ARM) : (!s ? HELD : done ? IDLE : REL);
        cnt_d    = (state_d == ARM || state_d == REL) ? cnt_inc : '0;
    end
`ifdef CALL_CANCEL_EN
    localparam logic [CW-1:0] HC_M = CW'(CANCEL_CYCLES);
    logic [CW-1:0] hc_q, hc_d;
    // hc saturates at the cancel length so a single press cancels at most once.
    always_comb hc_d = (state_q == HELD && state_d == HELD) ? (hc_q == HC_M ? hc_q : hc_q + CW'(1)) : '0;
    always_ff @(posedge CLK) begin
        if (RST) hc_q <= '0;
        else hc_q <= hc_d;
    end
`endif
    always_comb begin
        set = pressing && state_d == HELD;
`ifdef CALL_CANCEL_EN
        cancel = hc_d == HC_M && hc_q != HC_M;
`else
        cancel = 1'b0;
`endif
    end
endmodule

// File: rtl/elevator_call_latch.sv
// elevator_call_latch: debounced per-floor call latch with controller clear and pending count; CALL_CANCEL_EN enables hold-to-cancel
module elevator_call_latch
    import elevator_pkg::*;
#(
    parameter int NFLOORS       = DEF_NFLOORS,
    parameter int DEB_CYCLES    = 4,
    parameter int CANCEL_CYCLES = 16
) (
    input logic CLK,
    input logic RST,
    elevator_call_latch_if.slave bus
);
    localparam int PW = $clog2(NFLOORS + 1);
    logic [NFLOORS:1] set, cancel, b_q, b_d, cxl_q, cxl_d;
    logic [PW-1:0] pend_q, pend_d;
    for (genvar i = 1; i <= NFLOORS; i++) begin : g_floor
        elevator_button_debounce #(
            .DEB_CYCLES    (DEB_CYCLES),
            .CANCEL_CYCLES (CANCEL_CYCLES)
        ) u_deb (
            .CLK    (CLK),
            .RST    (RST),
            .p      (bus.P[i]),
            .set    (set[i]),
            .cancel (cancel[i])
        );
    end
    // R beats a coinciding set; a cancel only reports floors that actually had a call.
    always_comb begin
        b_d    = ~bus.R & (b_q | set) & ~cancel;
        cxl_d  = cancel & b_q;
        pend_d = PW'($countones(b_d));
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            b_q    <= '0;
            cxl_q  <= '0;
            pend_q <= '0;
        end else begin
            b_q    <= b_d;
            cxl_q  <= cxl_d;
            pend_q <= pend_d;
        end
    end
    assign bus.B    = b_q;
    assign bus.CXL  = cxl_q;
    assign bus.PEND = pend_q;
endmodule
